// File: rtl/axis_sm_fifo.sv
// AXI-Stream elastic buffer behind the FIR stream master.
// Holds up to pDEPTH words with their tlast marker. The FIR is back-pressured
// only when the buffer is full. Also counts delivered words and pulses once
// per delivered frame.
// Ports:
//   axis_clk, axis_rst_n         clock, async active-low reset
//   soft_clr                     sync flush of pointers and counters
//   s_tvalid/s_tdata/s_tlast     upstream stream in, s_tready out
//   m_tvalid/m_tdata/m_tlast     downstream stream out, m_tready in
//   level                        words currently stored
//   out_count                    saturating count of delivered words
//   frame_done                   one-cycle pulse after a tlast word is delivered
module axis_sm_fifo #(
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned pDEPTH      = 16,
    parameter int unsigned pCNT_WIDTH  = 16
) (
    input  logic                      axis_clk,
    input  logic                      axis_rst_n,
    input  logic                      soft_clr,
    input  logic                      s_tvalid,
    input  logic [pDATA_WIDTH-1:0]    s_tdata,
    input  logic                      s_tlast,
    output logic                      s_tready,
    output logic                      m_tvalid,
    output logic [pDATA_WIDTH-1:0]    m_tdata,
    output logic                      m_tlast,
    input  logic                      m_tready,
    output logic [$clog2(pDEPTH):0]   level,
    output logic [pCNT_WIDTH-1:0]     out_count,
    output logic                      frame_done
);

    localparam int unsigned AW = $clog2(pDEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = pDATA_WIDTH + 1;

    logic [EW-1:0]         mem_q [pDEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [pCNT_WIDTH-1:0] out_count_q, out_count_d;
    logic                  frame_done_q, frame_done_d;

    logic [PW-1:0]         level_c;
    logic                  full_c, empty_c, push_c, pop_c;
    logic [EW-1:0]         head_c;

    // Flags come from the pointers only, so no input reaches an output combinationally.
    assign level_c = wr_ptr_q - rd_ptr_q;
    assign full_c  = (level_c == PW'(pDEPTH));
    assign empty_c = (level_c == '0);
    assign head_c  = mem_q[rd_ptr_q[AW-1:0]];

    // soft_clr discards any handshake on its edge.
    assign push_c = s_tvalid && !full_c && !soft_clr;
    assign pop_c  = m_tready && !empty_c && !soft_clr;

    // Next-state for pointers, delivered-word counter and frame pulse.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        out_count_d  = out_count_q;
        frame_done_d = 1'b0;
        if (soft_clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            out_count_d = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_d     = rd_ptr_q + PW'(1);
                frame_done_d = head_c[EW-1];
                if (out_count_q != '1) begin
                    out_count_d = out_count_q + pCNT_WIDTH'(1);
                end
            end
        end
    end

    // Control state register.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            out_count_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_count_q  <= out_count_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage array; contents are meaningless while empty, so it has no reset.
    always_ff @(posedge axis_clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {s_tlast, s_tdata};
        end
    end

    assign s_tready   = !full_c;
    assign m_tvalid   = !empty_c;
    assign m_tdata    = head_c[pDATA_WIDTH-1:0];
    assign m_tlast    = head_c[EW-1];
    assign level      = level_c;
    assign out_count  = out_count_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_axis_sm_fifo.sv
module tb_axis_sm_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = 5;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n;
    logic          soft_clr;
    logic          s_tvalid;
    logic [DW-1:0] s_tdata;
    logic          s_tlast;
    logic          s_tready;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          m_tready;
    logic [LW-1:0] level;
    logic [15:0]   out_count;
    logic          frame_done;

    // Second instance with a 4-bit counter, sharing all inputs.
    logic          s_tready_s, m_tvalid_s, m_tlast_s, frame_done_s;
    logic [DW-1:0] m_tdata_s;
    logic [LW-1:0] level_s;
    logic [3:0]    out_count_s;

    always #5 axis_clk = ~axis_clk;

    axis_sm_fifo #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH), .pCNT_WIDTH(16)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .soft_clr(soft_clr),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
        .level(level), .out_count(out_count), .frame_done(frame_done)
    );

    axis_sm_fifo #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH), .pCNT_WIDTH(4)) dut_sat (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .soft_clr(soft_clr),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready_s),
        .m_tvalid(m_tvalid_s), .m_tdata(m_tdata_s), .m_tlast(m_tlast_s), .m_tready(m_tready),
        .level(level_s), .out_count(out_count_s), .frame_done(frame_done_s)
    );

    int          checks = 0;
    int          errors = 0;
    logic [32:0] sb[$];
    int          m_cnt;
    int          m_cnt_sat;
    logic        m_fd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_cnt     = 0;
        m_cnt_sat = 0;
        m_fd      = 1'b0;
    endtask

    // Drive one cycle (called at a falling edge), check outputs against the model,
    // then advance the model by the handshakes the model predicts.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l,
                         input logic r, input logic clr, output logic acc);
        logic [32:0] head;
        logic        pu, po;
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        m_tready = r;
        soft_clr = clr;
        #1;
        chk("s_tready", 64'(s_tready), 64'(sb.size() != DEPTH));
        chk("m_tvalid", 64'(m_tvalid), 64'(sb.size() != 0));
        chk("level", 64'(level), 64'(sb.size()));
        chk("out_count", 64'(out_count), 64'(m_cnt));
        chk("out_count_sat", 64'(out_count_s), 64'(m_cnt_sat));
        chk("frame_done", 64'(frame_done), 64'(m_fd));
        if (sb.size() != 0) chk("m_word", 64'({m_tlast, m_tdata}), 64'(sb[0]));
        pu  = v && (sb.size() != DEPTH);
        po  = r && (sb.size() != 0);
        acc = pu && !clr;
        if (clr) begin
            model_reset();
        end else begin
            m_fd = 1'b0;
            if (po) begin
                head = sb.pop_front();
                m_fd = head[32];
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_sat < 15) m_cnt_sat++;
            end
            if (pu) sb.push_back({l, d});
        end
        @(posedge axis_clk);
        @(negedge axis_clk);
    endtask

    initial begin
        logic acc;
        int   i;
        int   k;
        axis_rst_n = 1'b0;
        soft_clr   = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        s_tlast    = 1'b0;
        m_tready   = 1'b0;
        model_reset();
        repeat (2) @(negedge axis_clk);
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_s_tready", 64'(s_tready), 64'(1));
        chk("rst_out_count", 64'(out_count), 64'(0));
        chk("rst_frame_done", 64'(frame_done), 64'(0));
        axis_rst_n = 1'b1;

        // Pass-through: 600 words, last one ends the frame.
        for (int n = 0; n < 600; n++) cycle(1'b1, DW'($urandom), n == 599, 1'b1, 1'b0, acc);
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        chk("pt_out_count", 64'(out_count), 64'(600));

        // Fill to full with the consumer stalled, then drain.
        i = 0;
        repeat (22) begin
            cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b0, acc);
            if (acc) i++;
        end
        chk("fill_level", 64'(level), 64'(16));
        chk("fill_s_tready", 64'(s_tready), 64'(0));
        for (int n = 0; n < 80 && !(i == 20 && sb.size() == 0); n++) begin
            cycle(i < 20, DW'(i), 1'b0, 1'b1, 1'b0, acc);
            if (acc) i++;
        end
        chk("fill_drained_level", 64'(level), 64'(0));

        // Steady push+pop at level 5 across several pointer wraps.
        k = 1000;
        repeat (5) begin cycle(1'b1, DW'(k), 1'b0, 1'b0, 1'b0, acc); k++; end
        repeat (60) begin cycle(1'b1, DW'(k), k % 7 == 0, 1'b1, 1'b0, acc); k++; end
        chk("wrap_level", 64'(level), 64'(5));
        repeat (8) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);

        // Hold the head word under backpressure while upstream data changes.
        cycle(1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, acc);
        for (int n = 0; n < 7; n++) cycle(1'b1, DW'($urandom), n[0], 1'b0, 1'b0, acc);
        chk("hold_m_tdata", 64'(m_tdata), 64'(32'hA5A5_0001));
        chk("hold_m_tlast", 64'(m_tlast), 64'(1));
        repeat (12) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);

        // Asynchronous reset at level 9, observed before any clock edge.
        repeat (9) cycle(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0, acc);
        chk("pre_rst_level", 64'(level), 64'(9));
        #2;
        axis_rst_n = 1'b0;
        #1;
        chk("async_rst_level", 64'(level), 64'(0));
        chk("async_rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("async_rst_s_tready", 64'(s_tready), 64'(1));
        chk("async_rst_out_count", 64'(out_count), 64'(0));
        model_reset();
        s_tvalid = 1'b0;
        @(negedge axis_clk);
        axis_rst_n = 1'b1;

        // Soft clear at level 9 with a word offered on the same edge.
        repeat (9) cycle(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0, acc);
        repeat (3) cycle(1'b1, DW'($urandom), 1'b0, 1'b1, 1'b0, acc);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, acc);
        chk("clr_level", 64'(level), 64'(0));
        chk("clr_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("clr_out_count", 64'(out_count), 64'(0));
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);

        // 20 delivered words: 4-bit counter sticks at 15.
        for (int n = 0; n < 20; n++) cycle(1'b1, DW'(n + 77), 1'b0, 1'b1, 1'b0, acc);
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        chk("sat_out_count", 64'(out_count_s), 64'(15));
        chk("nosat_out_count", 64'(out_count), 64'(20));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axis_sm_fifo.md
Name: axis_sm_fifo

Overview:
- AXI-Stream elastic buffer placed directly downstream of the FIR stream master (sm_tvalid/sm_tdata/sm_tlast/sm_tready).
- Decouples FIR output from a consumer that stalls, so the FIR is back-pressured only when the buffer is full.
- Carries tlast through with each word.
- Counts delivered samples and pulses once per completed frame, for status/debug.

Parameters:
- pDATA_WIDTH, 32, stream data width (signed FIR result, passed through unmodified).
- pDEPTH, 16, FIFO depth in words; power of 2, minimum 2.
- pCNT_WIDTH, 16, width of delivered-sample counter.

Ports:
- axis_clk  in  1  clock; all logic on rising edge.
- axis_rst_n  in  1  asynchronous, active-low reset.
- soft_clr  in  1  synchronous flush of FIFO contents and counters.
- s_tvalid  in  1  upstream word valid (from FIR sm_tvalid).
- s_tdata  in  pDATA_WIDTH  upstream word.
- s_tlast  in  1  upstream last-of-frame marker.
- s_tready  out  1  buffer can accept (to FIR sm_tready).
- m_tvalid  out  1  downstream word valid.
- m_tdata  out  pDATA_WIDTH  downstream word.
- m_tlast  out  1  downstream last marker.
- m_tready  in  1  downstream accept.
- level  out  log2(pDEPTH)+1  words currently stored.
- out_count  out  pCNT_WIDTH  words delivered downstream since reset/clear; saturates at all-ones.
- frame_done  out  1  one-cycle pulse after the tlast word is delivered.

Behaviour:
- Storage:
  - pDEPTH x (pDATA_WIDTH+1) register array; tlast is stored alongside data.
  - wr_ptr and rd_ptr are log2(pDEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - level = wr_ptr - rd_ptr.
- Flags, all derived from registers only (no combinational path from s_tvalid or m_tready to any output):
  - empty = (level == 0).
  - full = (level == pDEPTH).
  - s_tready = !full.
  - m_tvalid = !empty.
  - m_tdata/m_tlast = array[rd_ptr] (first-word fall-through).
- Push: on an edge with s_tvalid && s_tready, write the word at wr_ptr and increment wr_ptr.
- Pop: on an edge with m_tvalid && m_tready, increment rd_ptr.
- Latency: a word pushed at edge N is presented with m_tvalid=1 right after edge N. Minimum pass-through is 1 cycle; there is no combinational bypass.
- Simultaneous push and pop on the same edge: both take effect and level is unchanged.
  - When full, s_tready=0, so no push occurs even if a pop happens that edge. s_tready rises the cycle after the pop.
  - When empty, m_tvalid=0, so no pop occurs; the pushed word appears next cycle.
- Pointer wrap: the index uses the low bits and wraps modulo pDEPTH; the MSB toggles on each wrap.
- Stability: while m_tvalid=1 and m_tready=0, m_tdata and m_tlast hold stable, as AXI-Stream requires.
- out_count: increments by 1 on each pop; saturates at 2^pCNT_WIDTH-1 with no wrap.
- frame_done: registered; equals 1 for exactly one cycle following an edge that popped a word with tlast=1. Otherwise 0.
- soft_clr=1 on an edge, with highest priority over push and pop:
  - wr_ptr, rd_ptr, out_count and frame_done go to 0.
  - Any push or pop on that same edge is discarded.
  - Array contents do not matter afterwards.
- Reset (axis_rst_n=0, asynchronous):
  - Pointers, out_count and frame_done are 0 immediately.
  - Consequently s_tready=1, m_tvalid=0, level=0.
  - m_tdata/m_tlast are don't-care while m_tvalid=0; the array itself is not reset.
  - Reset mid-frame drops all stored words; no partial-frame recovery.
- Data is not modified: no sign extension, truncation, or arithmetic on tdata.

Test Plan:
- Pass-through: m_tready=1; push 600 FIR outputs, last with tlast=1.
  - Every word appears in order one cycle after push.
  - out_count=600 at end.
  - frame_done pulses exactly once, the cycle after the tlast pop.
  - level never exceeds 1.
- Fill/full: m_tready=0; drive 20 words 0..19 continuously.
  - s_tready drops after 16 accepted; level=16.
  - Words 16..19 are held upstream.
  - Raise m_tready: data 0..19 emerges in order and level returns to 0.
- Simultaneous push/pop at level=5: level stays 5 for 10 cycles, and output order matches input order across the pointer wrap (run past 3 full wraps).
- Backpressure stability: m_tvalid=1, hold m_tready=0 for 7 cycles while s_tdata toggles. m_tdata and m_tlast do not change during the hold.
- Reset/clear mid-operation:
  - With level=9, assert axis_rst_n=0 between edges: level=0 and m_tvalid=0 without waiting for an edge.
  - Repeat with soft_clr=1 while s_tvalid=1: the word offered that edge is not stored and out_count=0.
- Counter saturation (pCNT_WIDTH=4): pop 20 words. out_count sticks at 15.
